mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 38 +++
 rtl/mul_div_unit_adder.sv | 18 +
 rtl/mul_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: the operation
// encoding, the controller state encoding and small decode helpers.
package Types;

  // Operation codes follow the RISC-V M-extension funct3 ordering.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } MulDivOp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } MulDivState;

  // True for the four division-family operations.
  function automatic logic opIsDiv(input MulDivOp op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  // True when operand A is interpreted as two's complement.
  function automatic logic opSignedA(input MulDivOp op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  // True when operand B is interpreted as two's complement.
  function automatic logic opSignedB(input MulDivOp op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mul_div_unit_adder.sv
// Plain ripple adder with carry-in. The multiply/divide datapath uses one
// instance for both the shift-add step and the restoring subtract step
// (subtract is done by feeding the inverted operand with carry-in set).
module Adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carryIn,
  output logic [WIDTH-1:0] o_sum
);

  // Sum of both operands plus the carry-in bit.
  always_comb begin
    o_sum = i_a + i_b + {{(WIDTH-1){1'b0}}, i_carryIn};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit. One radix-2 step per clock over the
// operand magnitudes, with sign correction applied when the result is
// written. Divide-by-zero and signed overflow resolve without iterating.
module mul_div_unit
  import Types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  MulDivOp          i_op,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
);

  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  MulDivState       r_state;
  MulDivOp          r_op;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_addend;
  logic             r_negMain;
  logic             r_negRem;
  logic [WIDTH-1:0] r_result;

  logic             w_negA;
  logic             w_negB;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic             w_divZero;
  logic             w_overflow;
  logic [WIDTH-1:0] w_specialResult;

  logic             w_isDiv;
  logic [WIDTH:0]   w_addA;
  logic [WIDTH:0]   w_addB;
  logic             w_carryIn;
  logic [WIDTH:0]   w_sum;
  logic             w_fits;

  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_prodFixed;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  // Decode the incoming request: operand magnitudes and the two cases that
  // finish immediately (divide by zero, most-negative / -1).
  always_comb begin
    w_negA     = opSignedA(i_op) & i_dataA[WIDTH-1];
    w_negB     = opSignedB(i_op) & i_dataB[WIDTH-1];
    w_absA     = w_negA ? -i_dataA : i_dataA;
    w_absB     = w_negB ? -i_dataB : i_dataB;
    w_divZero  = opIsDiv(i_op) && (i_dataB == '0);
    w_overflow = ((i_op == DIV) || (i_op == REM)) &&
                 (i_dataA == MOST_NEG) && (i_dataB == '1);
    w_specialResult = '0;
    if (w_divZero) begin
      w_specialResult = ((i_op == DIV) || (i_op == DIVU)) ? '1 : i_dataA;
    end else if (w_overflow) begin
      w_specialResult = (i_op == DIV) ? i_dataA : '0;
    end
  end

  // Steer the shared adder: add the multiplicand when the multiplier LSB is
  // set, or subtract the divisor from the partial remainder shifted left.
  always_comb begin
    w_isDiv = opIsDiv(r_op);
    if (w_isDiv) begin
      w_addA    = {r_hi, r_lo[WIDTH-1]};
      w_addB    = ~{1'b0, r_addend};
      w_carryIn = 1'b1;
    end else begin
      w_addA    = {1'b0, r_hi};
      w_addB    = r_lo[0] ? {1'b0, r_addend} : '0;
      w_carryIn = 1'b0;
    end
    w_fits = ~w_sum[WIDTH];
  end

  Adder #(
    .WIDTH(WIDTH + 1)
  ) u_adder (
    .i_a      (w_addA),
    .i_b      (w_addB),
    .i_carryIn(w_carryIn),
    .o_sum    (w_sum)
  );

  // Apply the sign correction and pick the result half for the operation.
  always_comb begin
    w_product   = {r_hi, r_lo};
    w_prodFixed = r_negMain ? -w_product : w_product;
    w_quot      = r_negMain ? -r_lo : r_lo;
    w_rem       = r_negRem ? -r_hi : r_hi;
    case (r_op)
      MUL:                  w_final = w_prodFixed[WIDTH-1:0];
      MULH, MULHSU, MULHU:  w_final = w_prodFixed[2*WIDTH-1:WIDTH];
      DIV, DIVU:            w_final = w_quot;
      REM, REMU:            w_final = w_rem;
      default:              w_final = '0;
    endcase
  end

  // Controller and datapath registers: accept, iterate, hold result.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_op      <= MUL;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_addend  <= '0;
      r_negMain <= 1'b0;
      r_negRem  <= 1'b0;
      r_result  <= '0;
    end else if (i_flush) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_op      <= i_op;
            r_negMain <= w_negA ^ w_negB;
            r_negRem  <= w_negA;
            r_count   <= '0;
            r_hi      <= '0;
            if (w_divZero || w_overflow) begin
              r_state  <= DONE;
              r_result <= w_specialResult;
            end else begin
              r_state <= BUSY;
              if (opIsDiv(i_op)) begin
                r_lo     <= w_absA;
                r_addend <= w_absB;
              end else begin
                r_lo     <= w_absB;
                r_addend <= w_absA;
              end
            end
          end
        end
        BUSY: begin
          if (r_count == LAST_COUNT) begin
            r_state  <= DONE;
            r_result <= w_final;
          end else begin
            r_count <= r_count + CW'(1);
            if (w_isDiv) begin
              r_hi <= w_fits ? w_sum[WIDTH-1:0] : w_addA[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_fits};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            r_state  <= IDLE;
            r_result <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_result <= '0;
        end
      endcase
    end
  end

  assign o_ready  = (r_state == IDLE);
  assign o_valid  = (r_state == DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed corner cases,
// flush/reset mid-operation, and randomized requests against an
// arithmetic reference model.
module tb_mul_div_unit;
  import Types::*;

  localparam int W = 32;

  logic          i_clock = 1'b0;
  logic          i_reset;
  MulDivOp       i_op;
  logic [W-1:0]  i_dataA;
  logic [W-1:0]  i_dataB;
  logic          i_valid;
  logic          o_ready;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_result;

  int            total = 0;
  int            bad = 0;
  logic          expPending = 1'b0;
  logic [W-1:0]  expResult = '0;

  always #5 i_clock = ~i_clock;

  mul_div_unit #(.WIDTH(W)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_op    (i_op),
    .i_dataA (i_dataA),
    .i_dataB (i_dataB),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic: 64-bit products and native SV division semantics.
  function automatic logic [W-1:0] model(input MulDivOp op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb, p;
    int ia, ib;
    ia = a;
    ib = b;
    case (op)
      MUL, MULH, MULHSU, MULHU: begin
        sa = (op == MULHU) ? longint'({32'b0, a}) : longint'($signed(a));
        sb = (op == MULHU || op == MULHSU) ? longint'({32'b0, b}) : longint'($signed(b));
        p  = sa * sb;
        return (op == MUL) ? p[31:0] : p[63:32];
      end
      DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      DIVU: return (b == 0) ? '1 : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit isShortcut(input MulDivOp op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    if (op inside {DIV, DIVU, REM, REMU} && b == 0) return 1'b1;
    if (op inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Every cycle: a visible result must be the expected one; otherwise zero.
  always @(negedge i_clock) begin
    if (i_reset === 1'b0) begin
      if (o_valid) begin
        checkOutput("validExpected", expPending, 1);
        checkOutput("resultMatch", o_result, expResult);
        checkOutput("readyLowInDone", o_ready, 0);
      end else begin
        checkOutput("resultZeroWhenInvalid", o_result, 0);
      end
    end
  end

  task automatic startRequest(input MulDivOp op, input logic [W-1:0] a,
                              input logic [W-1:0] b, output int expLat);
    int guard;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge i_clock);
      guard++;
    end
    checkOutput("readyBeforeRequest", o_ready, 1);
    i_op    = op;
    i_dataA = a;
    i_dataB = b;
    i_valid = 1'b1;
    @(posedge i_clock);
    expResult  = model(op, a, b);
    expPending = 1'b1;
    @(negedge i_clock);
    i_valid = 1'b0;
    i_dataA = $urandom;
    i_dataB = $urandom;
    i_op    = MulDivOp'(3'($urandom_range(0, 7)));
    checkOutput("readyLowAfterAccept", o_ready, 0);
    expLat = isShortcut(op, a, b) ? 0 : W + 1;
  endtask

  task automatic applyStimulus(input MulDivOp op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int hold);
    int lat, expLat;
    logic [W-1:0] held;
    startRequest(op, a, b, expLat);
    lat = 0;
    while (!o_valid && lat < W + 10) begin
      i_ready = 1'($urandom_range(0, 1));
      @(negedge i_clock);
      lat++;
    end
    i_ready = 1'b0;
    checkOutput("latency", lat, expLat);
    checkOutput("result", o_result, model(op, a, b));
    held = o_result;
    repeat (hold) begin
      @(negedge i_clock);
      checkOutput("heldResult", o_result, held);
      checkOutput("heldReadyLow", o_ready, 0);
      checkOutput("heldValid", o_valid, 1);
    end
    i_ready = 1'b1;
    @(posedge i_clock);
    expPending = 1'b0;
    @(negedge i_clock);
    i_ready = 1'b0;
    checkOutput("backToIdle", o_ready, 1);
    checkOutput("validDropped", o_valid, 0);
  endtask

  task automatic checkQuiet(input string name);
    logic sawValid;
    sawValid = 1'b0;
    repeat (W + 8) begin
      @(negedge i_clock);
      sawValid = sawValid | o_valid;
    end
    checkOutput(name, sawValid, 0);
  endtask

  // Abort via flush or reset after a given number of BUSY iterations.
  task automatic abortMidBusy(input bit useReset, input int iteration);
    int expLat;
    startRequest(MUL, 32'd12345, 32'd678, expLat);
    repeat (iteration - 1) @(negedge i_clock);
    if (useReset) i_reset = 1'b1;
    else          i_flush = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clock);
    expPending = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    checkOutput(useReset ? "resetReady" : "flushReady", o_ready, 1);
    checkOutput(useReset ? "resetValid" : "flushValid", o_valid, 0);
    checkOutput(useReset ? "resetResult" : "flushResult", o_result, 0);
    checkQuiet(useReset ? "quietAfterReset" : "quietAfterFlush");
  endtask

  initial begin
    int dummy;
    i_reset = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op    = MUL;
    i_dataA = '0;
    i_dataB = '0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    checkOutput("resetValid0", o_valid, 0);
    checkOutput("resetReady1", o_ready, 1);
    checkOutput("resetResult0", o_result, 0);
    i_reset = 1'b0;

    // Pin the model against hand-computed values.
    checkOutput("modelMUL", model(MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    checkOutput("modelMULH", model(MULH, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    checkOutput("modelMULHU", model(MULHU, '1, '1), 32'hFFFF_FFFE);
    checkOutput("modelMULHSU", model(MULHSU, '1, '1), 32'hFFFF_FFFF);
    checkOutput("modelDIV", model(DIV, -32'd7, 32'd2), 32'hFFFF_FFFD);
    checkOutput("modelREM", model(REM, -32'd7, 32'd2), 32'hFFFF_FFFF);
    checkOutput("modelDIVU", model(DIVU, '1, 32'h10), 32'h0FFF_FFFF);
    checkOutput("modelDIVU0", model(DIVU, 32'd5, '0), 32'hFFFF_FFFF);
    checkOutput("modelREMU0", model(REMU, 32'd5, '0), 32'd5);
    checkOutput("modelDIVovf", model(DIV, 32'h8000_0000, '1), 32'h8000_0000);
    checkOutput("modelREMovf", model(REM, 32'h8000_0000, '1), 32'd0);

    // Directed corner cases.
    applyStimulus(MUL, 32'd7, 32'hFFFF_FFFD, 1);
    applyStimulus(MULH, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(MULHU, '1, '1, 0);
    applyStimulus(MULHSU, '1, '1, 0);
    applyStimulus(DIV, -32'd7, 32'd2, 0);
    applyStimulus(REM, -32'd7, 32'd2, 0);
    applyStimulus(DIVU, '1, 32'h10, 0);
    applyStimulus(DIVU, 32'd5, '0, 0);
    applyStimulus(REMU, 32'd5, '0, 0);
    applyStimulus(DIV, 32'h8000_0000, '1, 0);
    applyStimulus(REM, 32'h8000_0000, '1, 0);
    applyStimulus(DIV, 32'd100, 32'd7, 5);

    // Flush at iteration 10, then a clean request.
    abortMidBusy(1'b0, 10);
    applyStimulus(MULHSU, 32'hFFFF_FF00, 32'h1234_5678, 0);

    // Flush in IDLE outranks a request on the same edge.
    @(negedge i_clock);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_op    = MUL;
    @(negedge i_clock);
    i_flush = 1'b0;
    i_valid = 1'b0;
    checkOutput("flushIdleReady", o_ready, 1);
    checkQuiet("quietAfterIdleFlush");

    // Flush while DONE discards the held result.
    startRequest(DIVU, 32'd9, '0, dummy);
    i_flush = 1'b1;
    @(posedge i_clock);
    expPending = 1'b0;
    @(negedge i_clock);
    i_flush = 1'b0;
    checkOutput("flushDoneValid", o_valid, 0);
    checkOutput("flushDoneReady", o_ready, 1);

    // Reset at iteration 20, then a clean request.
    abortMidBusy(1'b1, 20);
    applyStimulus(REM, 32'd1000, -32'd33, 0);

    // Randomized requests.
    for (int n = 0; n < 150; n++) begin
      applyStimulus(MulDivOp'(3'($urandom_range(0, 7))), pickOperand(), pickOperand(),
                    $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
